// File: rtl/counter_sched_pkg.sv
// Shared request encoding and helpers for the counter command scheduler.
package counter_sched_pkg;

    localparam int REQ_RST  = 0;
    localparam int REQ_UP   = 1;
    localparam int REQ_DN   = 2;
    localparam int REQ_AUTO = 3;
    localparam int NUM_REQ  = 4;

    typedef logic [NUM_REQ-1:0] req_vec_t;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Lowest index wins, so the request constants double as the priority order.
    function automatic req_vec_t pick_highest(input req_vec_t req);
        req_vec_t gnt;
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (gnt == '0)) begin
                gnt[i] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/cmd_prescaler.sv
// Free-running down-counter prescaler; emits a one-cycle tick each time it wraps.
module cmd_prescaler #(
    parameter int                   DIV_WIDTH   = 24,
    parameter logic [DIV_WIDTH-1:0] DIV_DEFAULT = 24'h100000
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 cfg_div_we,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] reload_q;
    logic                 tick_q;

    // A config write restarts the period and beats a simultaneous wrap.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            reload_q <= DIV_DEFAULT;
            div_q    <= DIV_DEFAULT;
            tick_q   <= 1'b0;
        end else if (cfg_div_we) begin
            reload_q <= cfg_div;
            div_q    <= cfg_div;
            tick_q   <= 1'b0;
        end else if (div_q == '0) begin
            div_q    <= reload_q;
            tick_q   <= 1'b1;
        end else begin
            div_q    <= div_q - 1'b1;
            tick_q   <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/counter_cmd_sched.sv
// Sticky request latching, fixed-priority arbitration and the host-visible counter.
module counter_cmd_sched
    import counter_sched_pkg::*;
#(
    parameter int                   WIDTH       = 8,
    parameter int                   DIV_WIDTH   = 24,
    parameter logic [DIV_WIDTH-1:0] DIV_DEFAULT = 24'h100000
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 cfg_enable,
    input  logic                 cfg_autocount,
    input  logic                 cfg_div_we,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0]     cfg_match,
    input  logic                 trig_reset,
    input  logic                 trig_up,
    input  logic                 trig_down,
    output logic [WIDTH-1:0]     count,
    output logic                 evt_zero,
    output logic                 evt_max,
    output logic                 evt_match,
    output logic                 busy,
    output logic [7:0]           drop_count
);

    logic tick;

    cmd_prescaler #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_prescaler (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .cfg_div_we (cfg_div_we),
        .cfg_div    (cfg_div),
        .tick       (tick)
    );

    req_vec_t         pend_q, pend_d;
    req_vec_t         req_in, grant, clr_mask, drop_vec;
    logic [WIDTH-1:0] count_q, count_d;
    logic             evt_zero_q, evt_zero_d;
    logic             evt_max_q, evt_max_d;
    logic             evt_match_q, evt_match_d;
    logic [7:0]       drop_q, drop_d;
    logic [8:0]       drop_sum;
    logic             served;

    always_comb begin
        req_in           = '0;
        req_in[REQ_RST]  = trig_reset;
        req_in[REQ_UP]   = trig_up;
        req_in[REQ_DN]   = trig_down;
        req_in[REQ_AUTO] = tick & cfg_autocount;

        grant  = cfg_enable ? pick_highest(pend_q) : '0;
        served = |grant;

        // A reset serve flushes every pending bit; fresh pulses still land.
        clr_mask = grant[REQ_RST] ? '1 : grant;
        drop_vec = req_in & pend_q & ~clr_mask;
        pend_d   = (pend_q & ~clr_mask) | req_in;

        count_d = count_q;
        if (grant[REQ_RST]) begin
            count_d = '0;
        end else if (grant[REQ_UP] || grant[REQ_AUTO]) begin
            count_d = count_q + 1'b1;
        end else if (grant[REQ_DN]) begin
            count_d = count_q - 1'b1;
        end

        evt_zero_d  = served && (count_d == '0);
        evt_max_d   = served && (count_d == '1);
        evt_match_d = served && (count_d == cfg_match);

        drop_sum = {1'b0, drop_q} + 9'($countones(drop_vec));
        drop_d   = drop_sum[8] ? DROP_MAX : drop_sum[7:0];
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            pend_q      <= '0;
            count_q     <= '0;
            evt_zero_q  <= 1'b0;
            evt_max_q   <= 1'b0;
            evt_match_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            pend_q      <= pend_d;
            count_q     <= count_d;
            evt_zero_q  <= evt_zero_d;
            evt_max_q   <= evt_max_d;
            evt_match_q <= evt_match_d;
            drop_q      <= drop_d;
        end
    end

    assign count      = count_q;
    assign evt_zero   = evt_zero_q;
    assign evt_max    = evt_max_q;
    assign evt_match  = evt_match_q;
    assign busy       = |pend_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Scoreboard bench: a per-cycle behavioural model queues expected outputs, a monitor compares.
module tb_counter_cmd_sched;

    localparam int DIV_DEF = 24'h100000;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_enable = 1'b0;
    logic        cfg_autocount = 1'b0;
    logic        cfg_div_we = 1'b0;
    logic [23:0] cfg_div = '0;
    logic [7:0]  cfg_match = '0;
    logic        trig_reset = 1'b0;
    logic        trig_up = 1'b0;
    logic        trig_down = 1'b0;
    logic [7:0]  count;
    logic        evt_zero, evt_max, evt_match, busy;
    logic [7:0]  drop_count;

    counter_cmd_sched dut (
        .sys_clk       (sys_clk),
        .reset_n       (reset_n),
        .cfg_enable    (cfg_enable),
        .cfg_autocount (cfg_autocount),
        .cfg_div_we    (cfg_div_we),
        .cfg_div       (cfg_div),
        .cfg_match     (cfg_match),
        .trig_reset    (trig_reset),
        .trig_up       (trig_up),
        .trig_down     (trig_down),
        .count         (count),
        .evt_zero      (evt_zero),
        .evt_max       (evt_max),
        .evt_match     (evt_match),
        .busy          (busy),
        .drop_count    (drop_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int cnt;
        bit ez;
        bit em;
        bit et;
        bit bsy;
        int drop;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nmis = 0;

    // Reference model state: counter value, set of pending requests, prescaler phase.
    int m_cnt = 0;
    bit m_pend[4];
    int m_drop = 0;
    int m_reload = DIV_DEF;
    int m_since_load = 0;

    task automatic model_cycle();
        bit   tick_now, newreq[4];
        int   srv;
        exp_t e;
        tick_now = (m_since_load > 0) && ((m_since_load % (m_reload + 1)) == 0);
        e.ez = 0; e.em = 0; e.et = 0;
        if (!reset_n) begin
            m_cnt = 0; m_drop = 0; m_reload = DIV_DEF; m_since_load = 0;
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
        end else begin
            newreq[0] = trig_reset; newreq[1] = trig_up; newreq[2] = trig_down;
            newreq[3] = tick_now && cfg_autocount;
            srv = -1;
            if (cfg_enable)
                for (int i = 0; i < 4; i++)
                    if (m_pend[i] && srv < 0) srv = i;
            if (srv == 0) begin
                for (int i = 0; i < 4; i++) m_pend[i] = newreq[i];
                m_cnt = 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (newreq[i] && m_pend[i] && i != srv && m_drop < 255) m_drop++;
                    m_pend[i] = (m_pend[i] && i != srv) || newreq[i];
                end
                if (srv == 1 || srv == 3) m_cnt = (m_cnt + 1) % 256;
                if (srv == 2) m_cnt = (m_cnt + 255) % 256;
            end
            if (srv >= 0) begin
                e.ez = (m_cnt == 0);
                e.em = (m_cnt == 255);
                e.et = (m_cnt == int'(cfg_match));
            end
            if (cfg_div_we) begin
                m_reload = int'(cfg_div);
                m_since_load = 0;
            end else begin
                m_since_load++;
            end
        end
        e.cnt  = m_cnt;
        e.bsy  = m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
        e.drop = m_drop;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nmis++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", int'(count), e.cnt);
                chk("evt_zero", int'(evt_zero), int'(e.ez));
                chk("evt_max", int'(evt_max), int'(e.em));
                chk("evt_match", int'(evt_match), int'(e.et));
                chk("busy", int'(busy), int'(e.bsy));
                chk("drop_count", int'(drop_count), e.drop);
            end
        end
    end

    task automatic step();
        @(negedge sys_clk);
        model_cycle();
        @(posedge sys_clk);
        #1;
        trig_reset = 0; trig_up = 0; trig_down = 0; cfg_div_we = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input bit r, input bit u, input bit d);
        trig_reset = r; trig_up = u; trig_down = d;
        step();
    endtask

    initial begin : driver
        reset_n = 0;
        idle(2);
        reset_n = 1; cfg_enable = 1;
        idle(7);
        pulse(0, 1, 0); idle(4);
        repeat (4) begin pulse(0, 1, 0); idle(2); end
        pulse(0, 1, 1); idle(4);
        pulse(1, 0, 0); idle(2); pulse(0, 0, 1); idle(2);
        pulse(0, 1, 0); idle(2); pulse(0, 0, 1); idle(2);
        cfg_enable = 0;
        pulse(0, 1, 0); idle(2); pulse(0, 1, 0); idle(1); pulse(1, 0, 0); idle(1);
        cfg_enable = 1; idle(4);
        pulse(1, 0, 0); idle(2);
        cfg_div_we = 1; cfg_div = 24'd3; cfg_autocount = 1; cfg_match = 8'd2;
        step(); idle(20);
        cfg_autocount = 0; idle(3);
        pulse(1, 0, 0); idle(2);
        repeat (7) begin pulse(0, 1, 0); idle(1); end
        cfg_enable = 0; pulse(0, 1, 0); idle(1);
        reset_n = 0; step(); reset_n = 1; cfg_enable = 1; idle(3);
        cfg_enable = 0;
        repeat (300) pulse(0, 1, 0);
        cfg_enable = 1; idle(3);
        cfg_div_we = 1; cfg_div = 24'd0; step(); idle(2);
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom % 200) != 0;
            cfg_enable = ($urandom % 8) != 0;
            if ($urandom % 64 == 0) cfg_autocount = ~cfg_autocount;
            if ($urandom % 100 == 0) begin cfg_div_we = 1; cfg_div = 24'($urandom % 6); end
            if ($urandom % 50 == 0) cfg_match = 8'($urandom);
            trig_reset = ($urandom % 23) == 0;
            trig_up = ($urandom % 3) == 0;
            trig_down = ($urandom % 4) == 0;
            step();
        end
        reset_n = 1;
        idle(2);
        @(negedge sys_clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/counter_cmd_sched.md
Name: counter_cmd_sched

Overview:
Command scheduler for an 8-bit host-controlled counter in the FrontPanel counters design. Host trigger pulses (reset/up/down) and an internal prescaler tick are latched as sticky requests. Requests are arbitrated at one per cycle with fixed priority and applied to the counter. Registered event pulses on count update are suitable for okTriggerOut; count is suitable for okWireOut.

Parameters:
WIDTH, 8, counter width
DIV_WIDTH, 24, prescaler width
DIV_DEFAULT, 24'h100000, prescaler reload value after reset

Ports:
sys_clk  in  1  single clock; all logic on its rising edge
reset_n  in  1  synchronous active-low reset
cfg_enable  in  1  1 = service pending requests
cfg_autocount  in  1  1 = prescaler ticks generate up requests
cfg_div_we  in  1  load cfg_div into reload register and restart prescaler
cfg_div  in  DIV_WIDTH  new prescaler reload value
cfg_match  in  WIDTH  compare value for evt_match
trig_reset  in  1  host reset pulse
trig_up  in  1  host increment pulse
trig_down  in  1  host decrement pulse
count  out  WIDTH  current counter value
evt_zero  out  1  1-cycle pulse: count just updated to 0
evt_max  out  1  1-cycle pulse: count just updated to all-ones
evt_match  out  1  1-cycle pulse: count just updated to cfg_match
busy  out  1  any request pending
drop_count  out  8  saturating count of lost requests

Behaviour:
- Reset (reset_n=0 at edge): count=0; pending bits=0; reload=DIV_DEFAULT; div=DIV_DEFAULT; tick=0; evt_*=0; drop_count=0. Reset applied mid-operation discards all pending requests.
- Prescaler: div decrements every cycle.
  - div==0: div<=reload, tick<=1 for one cycle.
  - cfg_div_we: reload<=cfg_div, div<=cfg_div, tick<=0. cfg_div_we overrides the zero reload.
  - reload=0: tick every cycle.
  - Prescaler runs regardless of cfg_enable.
- Pending bits pend_rst, pend_up, pend_dn, pend_auto:
  - Set at the edge after trig_reset, trig_up, trig_down, or (tick & cfg_autocount), respectively.
- Arbiter: when cfg_enable=1 and any pending bit is set, serve the highest-priority registered pending bit each cycle.
  - Priority: rst > up > dn > auto.
  - Served bit clears at the same edge.
  - rst serve: count<=0 and also clears pend_up/pend_dn/pend_auto (flush).
  - up/auto serve: count<=count+1, wrap FF->00.
  - dn serve: count<=count-1, wrap 00->FF.
- Latency: trigger pulse in cycle N -> pending at edge N+1 -> count updated at edge N+2 if no higher-priority request is pending.
- Simultaneous events:
  - New pulse on a bit that is being served in the same cycle: bit remains set (set wins); no drop.
  - New pulse on a bit already set and not served: drop_count+1, saturating at 255.
  - A flush by rst does not count as a drop. A pulse arriving in the flush cycle re-sets its bit.
- cfg_enable=0: no service; pulses still latch; count holds.
- Events: asserted for exactly one cycle, registered at the same edge as the count update. Based on the new value. Only on a serve, never on idle cycles.
  - Reset serve while count already 0 still fires evt_zero.
  - Multiple evt_* may fire together, e.g. cfg_match=0 with evt_zero.
- busy = OR of registered pending bits.

Decomposition:
- Package counter_sched_pkg:
  - request index constants REQ_RST=0, REQ_UP=1, REQ_DN=2, REQ_AUTO=3;
  - req_vec_t (4-bit);
  - DROP_MAX=8'hFF.
- Sub-module cmd_prescaler holds the div/reload/tick logic (ports sys_clk, reset_n, cfg_div_we, cfg_div, tick).
- Arbiter, pending bits and counter stay in the top level.

Test Plan:
- Reset, cfg_enable=1, trig_up pulse at cycle 10 -> count=1 at edge 12; busy high in cycle 11 only; no evt_*.
- trig_up and trig_down in the same cycle from count=5 -> edge+2 count=6, edge+3 count=5; drop_count=0.
- count=FF, trig_up -> count=00 with evt_zero pulse exactly 1 cycle. Then trig_down -> count=FF with evt_max.
- cfg_enable=0; trig_up twice 3 cycles apart, then trig_reset; cfg_enable=1 -> drop_count=1; single rst serve sets count=0 and flushes up; evt_zero=1; busy=0 the next cycle.
- cfg_div_we with cfg_div=3, cfg_autocount=1 -> tick every 4 cycles; count increments by 1 per tick; cfg_match=2 gives evt_match on the 2nd increment.
- reset_n low while pend_up set and count=7 -> next cycle count=0, busy=0, drop_count=0, no evt_*.
